enet_rx_buf: RTL
================

Name: enet_rx_buf

Overview:
- Receive-side word buffer between the Ethernet receiver and the CPU54 data bus.
- Captures each 32-bit word the receiver presents with its single-cycle acknowledge pulse and queues it in a FIFO.
- Raises a CPU interrupt and gives the CPU a memory-mapped data/status register pair, so words are not lost when the CPU is slow to service the receiver.
- Replaces the single-bit interrupt latch in the top level.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (default 16 entries).
- DATA_W, 32, width of a received word and of the CPU read bus.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle pulse from the receiver: word on rx_data is valid.
- rx_data  input  DATA_W  received word; sampled only when rx_valid=1.
- cs  input  1  CPU bus select for this block (address decode).
- rd  input  1  CPU read strobe.
- reg_sel  input  1  0 = DATA register, 1 = STATUS register (address bit 2).
- rdata  output  DATA_W  combinational read data to the CPU.
- intr  output  1  interrupt request to the CPU, level.
- inta  input  1  interrupt acknowledge from the CPU, one-cycle pulse.
- overflow  output  1  sticky overflow flag, also readable in STATUS.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, count=0, pointers=0, overflow=0, intr=0, state=IDLE. rdata shows the STATUS value when selected, else 0.
- Push:
  - On a clk edge with rx_valid=1 and (not full, or a pop in the same cycle), rx_data is written at wr_ptr.
  - wr_ptr advances modulo 2^DEPTH_LOG2.
- Drop:
  - rx_valid=1 while full with no simultaneous pop: word dropped, overflow set to 1 (sticky).
- Pop:
  - cs=1, rd=1, reg_sel=0 and not empty: rdata = mem[rd_ptr] combinationally in the same cycle.
  - rd_ptr advances at the end of that cycle.
  - The CPU sees the head word with zero latency; the next word is visible one cycle later.
- Empty read: cs=1, rd=1, reg_sel=0 while empty returns 0; pointers unchanged.
- Simultaneous push and pop: both performed, count unchanged. This is legal when full (no overflow) but not when empty (the pop is ignored and the push is accepted).
- count:
  - DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- STATUS read (cs=1, rd=1, reg_sel=1):
  - Layout: bit0 empty, bit1 full, bit2 overflow, bits[3+DEPTH_LOG2:3] count, next two bits the state encoding. All other bits are 0.
  - Reading STATUS clears overflow at the end of the cycle. If a new overflow occurs in that same cycle, the set wins.
- rdata when cs=0 or rd=0: 0.
- Interrupt state machine:
  - Encoding: IDLE=00, PENDING=01, SERVICE=10. intr=1 only in PENDING.
  - IDLE -> PENDING on an accepted push.
  - PENDING -> SERVICE on inta=1.
  - PENDING -> IDLE if the FIFO becomes empty through polled reads before inta arrives.
  - SERVICE -> IDLE when count reaches 0 after a pop with no push in the same cycle.
  - Pushes during SERVICE keep the state in SERVICE; no re-interrupt, the CPU drains until empty.
  - inta in IDLE or SERVICE is ignored.
  - A push and the draining pop in the same SERVICE cycle keep the state in SERVICE.
- Reset mid-operation: all state cleared immediately; contents discarded; intr drops asynchronously.
- Single clock: rx_valid and inta are synchronous to clk; no CDC logic in this block.

Test Plan:
- Reset then 3 pushes 0xA1, 0xB2, 0xC3 -> intr=1 one cycle after the first push. STATUS = count 3, empty 0, state PENDING. Three DATA reads return 0xA1, 0xB2, 0xC3 in order, then empty=1 and state IDLE.
- 16 pushes then a 17th push 0xDEAD -> full=1, overflow=1, 0xDEAD absent. A STATUS read returns bit2=1, and the next STATUS read returns bit2=0.
- Full FIFO with push 0x55 and DATA read in the same cycle -> the read returns the oldest word, 0x55 is stored, count stays 16, overflow stays 0.
- Push 0x11, inta pulse -> intr=0, state SERVICE. Push 0x22 during SERVICE -> intr stays 0. Two DATA reads return 0x11 and 0x22, then state IDLE. A further push raises intr again.
- DATA read while empty -> rdata=0, count stays 0. Push 0x77 in the same cycle as an empty read -> count=1 and the next read returns 0x77.
- Drive rst_n low mid-stream with count=5 and intr=1 -> intr=0 and count=0 without waiting for a clk edge. After release, a STATUS read returns 0x1 (empty only).

Source files
------------

// File: rtl/enet_rx_buf.sv
// Receive-side word buffer between the Ethernet receiver and the CPU bus.
// Received words are queued in a FIFO. The CPU sees a DATA register that pops
// with zero latency and a STATUS register. An interrupt state machine raises
// intr once per burst, and the CPU drains the FIFO until it is empty.
module enet_rx_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              cs,
    input  logic              rd,
    input  logic              reg_sel,
    output logic [DATA_W-1:0] rdata,
    output logic              intr,
    input  logic              inta,
    output logic              overflow
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        SERVICE = 2'b10
    } state_t;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    state_t                state_q;
    logic                  intr_q;

    logic empty;
    logic full;
    logic data_rd;
    logic stat_rd;
    logic pop;
    logic push;
    logic drop;
    logic drain_to_empty;
    logic [DATA_W-1:0] status;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign data_rd = cs & rd & ~reg_sel;
    assign stat_rd = cs & rd & reg_sel;
    // A read of an empty FIFO is not a pop, so a push into an empty FIFO always wins.
    assign pop     = data_rd & ~empty;
    assign push    = rx_valid & (~full | pop);
    assign drop    = rx_valid & full & ~pop;
    // The last word leaves the FIFO and nothing replaces it in this cycle.
    assign drain_to_empty = pop & ~push & (count_q == ONE_CNT);

    assign intr     = intr_q;
    assign overflow = overflow_q;

    // Next-state values for the occupancy counter and the sticky overflow flag
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (stat_rd) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    // STATUS layout and the combinational CPU read mux
    always_comb begin
        status = '0;
        status[0] = empty;
        status[1] = full;
        status[2] = overflow_q;
        status[3 +: DEPTH_LOG2 + 1] = count_q;
        status[4 + DEPTH_LOG2 +: 2] = state_q;
        rdata = '0;
        if (stat_rd)
            rdata = status;
        else if (pop)
            rdata = mem_q[rd_ptr_q];
    end

    // Word storage; contents are not reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    // Pointers, count and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Interrupt FSM; emptying the FIFO takes priority over inta in PENDING so
    // SERVICE is never entered with nothing left to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= PENDING;
                        intr_q  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (drain_to_empty) begin
                        state_q <= IDLE;
                        intr_q  <= 1'b0;
                    end else if (inta) begin
                        state_q <= SERVICE;
                        intr_q  <= 1'b0;
                    end
                end
                SERVICE: begin
                    intr_q <= 1'b0;
                    if (drain_to_empty) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
